// File: rtl/rr_hold_arbiter.sv
// Round-robin arbiter with multi-cycle grant ownership.
// A grant ends on done, on the owner dropping req, or at the hold limit.
module rr_hold_arbiter #(
    parameter int N        = 16,
    parameter int IDXW     = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic            done,
    output logic [N-1:0]    gnt,
    output logic [IDXW-1:0] gnt_idx,
    output logic            gnt_vld,
    output logic            timeout
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t          state;
    state_t          state_nxt;
    logic [IDXW-1:0] ptr;
    logic [IDXW-1:0] ptr_nxt;
    logic [7:0]      hold_cnt;
    logic [7:0]      hold_nxt;
    logic [N-1:0]    gnt_nxt;
    logic [IDXW-1:0] idx_nxt;
    logic            vld_nxt;
    logic            to_nxt;

    logic            win_found;
    logic [IDXW-1:0] win_idx;
    logic [IDXW-1:0] cand;
    logic            owner_req;
    logic            rel_lim;
    logic            rel;

    // Descending scan so the offset closest to ptr is written last and wins
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr;
        cand      = ptr;
        for (int k = N - 1; k >= 0; k--) begin
            cand = ptr + IDXW'(k);
            if (req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign owner_req = req[gnt_idx];
    assign rel_lim   = (hold_cnt == HOLD_LAST);
    assign rel       = done | ~owner_req | rel_lim;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            hold_cnt <= '0;
            gnt      <= '0;
            gnt_idx  <= '0;
            gnt_vld  <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            hold_cnt <= hold_nxt;
            gnt      <= gnt_nxt;
            gnt_idx  <= idx_nxt;
            gnt_vld  <= vld_nxt;
            timeout  <= to_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (win_found) state_nxt = BUSY;
            BUSY: if (rel) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ptr_nxt  = ptr;
        hold_nxt = hold_cnt;
        gnt_nxt  = gnt;
        idx_nxt  = gnt_idx;
        vld_nxt  = gnt_vld;
        to_nxt   = 1'b0;
        unique case (state)
            IDLE: begin
                if (win_found) begin
                    gnt_nxt  = {{(N-1){1'b0}}, 1'b1} << win_idx;
                    idx_nxt  = win_idx;
                    vld_nxt  = 1'b1;
                    hold_nxt = '0;
                end
            end
            BUSY: begin
                hold_nxt = hold_cnt + 8'd1;
                if (rel) begin
                    gnt_nxt  = '0;
                    vld_nxt  = 1'b0;
                    hold_nxt = '0;
                    ptr_nxt  = gnt_idx + IDXW'(1);
                    // Timeout flags only releases the hold limit forced
                    to_nxt   = rel_lim & ~done & owner_req;
                end
            end
            default: begin
                gnt_nxt = '0;
                vld_nxt = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_rr_hold_arbiter.sv
// Scoreboard bench for rr_hold_arbiter: directed grants queued as
// expected transactions, checked by a grant-tracking monitor.
module tb_rr_hold_arbiter;

    localparam int N    = 16;
    localparam int IDXW = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic            done;
    logic [N-1:0]    gnt;
    logic [IDXW-1:0] gnt_idx;
    logic            gnt_vld;
    logic            timeout;

    rr_hold_arbiter #(.N(N), .IDXW(IDXW), .MAX_HOLD(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        int idx;
        int len;
        bit to;
        int idx_after;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    bit   mon_en = 1'b0;
    bit   prev_vld = 1'b0;
    int   cur_idx = 0;
    int   cur_len = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input int idx, input int len, input bit to, input int idx_after);
        exp_t e;
        e.idx = idx;
        e.len = len;
        e.to = to;
        e.idx_after = idx_after;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            chk("onehot", 32'($onehot0(gnt)), 1);
            chk("vld_or", 32'(gnt_vld), 32'(|gnt));
            if (gnt_vld) chk("gnt_at_idx", 32'(gnt[gnt_idx]), 1);
            if (gnt_vld && !prev_vld) begin
                cur_idx = int'(gnt_idx);
                cur_len = 1;
                chk("timeout_in_grant", 32'(timeout), 0);
            end else if (gnt_vld) begin
                cur_len++;
                chk("idx_stable", 32'(gnt_idx), cur_idx);
                chk("timeout_in_grant", 32'(timeout), 0);
            end else if (prev_vld) begin
                chk("grant_expected", 32'(q.size() != 0), 1);
                if (q.size() != 0) begin
                    exp_t e;
                    e = q.pop_front();
                    chk("grant_idx", cur_idx, e.idx);
                    chk("grant_len", cur_len, e.len);
                    chk("release_timeout", 32'(timeout), 32'(e.to));
                    chk("idx_after_release", 32'(gnt_idx), e.idx_after);
                end
            end else begin
                chk("timeout_idle", 32'(timeout), 0);
            end
            prev_vld = gnt_vld;
        end
    end

    initial begin
        rst = 1'b1;
        req = '0;
        done = 1'b0;
        step(2);
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_idx", 32'(gnt_idx), 0);
        chk("rst_vld", 32'(gnt_vld), 0);
        chk("rst_timeout", 32'(timeout), 0);
        mon_en = 1'b1;
        rst = 1'b0;

        // single requester, done in 3rd grant cycle, then re-grant
        req = 16'h0001;
        push(0, 3, 1'b0, 0);
        step(3);
        done = 1'b1;
        step(1);
        done = 1'b0;
        chk("ptr_after_t1", 32'(dut.ptr), 1);
        push(0, 1, 1'b0, 0);
        step(1);
        done = 1'b1;
        step(1);
        done = 1'b0;
        req = '0;

        // full rotation from ptr=0
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        for (int i = 0; i < 17; i++) push(i % 16, 1, 1'b0, i % 16);
        req = 16'hFFFF;
        done = 1'b1;
        step(34);
        req = '0;
        done = 1'b0;

        // hold-limit release of index 5, then re-grant
        req = 16'h0020;
        push(5, 8, 1'b1, 5);
        step(9);
        push(5, 1, 1'b0, 5);
        step(1);
        done = 1'b1;
        step(1);
        done = 1'b0;
        req = '0;

        // wrap-around: serve 14, then 15 before 0
        req = 16'h4000;
        push(14, 1, 1'b0, 14);
        step(1);
        done = 1'b1;
        step(1);
        req = 16'h8001;
        push(15, 1, 1'b0, 15);
        push(0, 1, 1'b0, 0);
        step(4);
        done = 1'b0;
        req = '0;

        // owner drops request; done while idle is ignored
        req = 16'h0004;
        push(2, 2, 1'b0, 2);
        step(2);
        req = '0;
        step(1);
        chk("ptr_after_drop", 32'(dut.ptr), 3);
        done = 1'b1;
        step(1);
        done = 1'b0;
        step(2);
        chk("idle_after_done", 32'(gnt_vld), 0);

        // reset mid-grant
        req = 16'h0100;
        push(8, 3, 1'b0, 0);
        step(3);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("mid_rst_ptr", 32'(dut.ptr), 0);
        chk("mid_rst_gnt", 32'(gnt), 0);
        req = 16'h0101;
        push(0, 1, 1'b0, 0);
        step(1);
        done = 1'b1;
        step(1);
        done = 1'b0;
        req = '0;

        // done coincides with hold limit: normal release
        req = 16'h0008;
        push(3, 8, 1'b0, 3);
        step(8);
        done = 1'b1;
        step(1);
        done = 1'b0;
        req = '0;

        for (int i = 0; i < 50 && q.size() != 0; i++) step(1);
        step(3);
        chk("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rr_hold_arbiter.md
# rr_hold_arbiter

Sixteen-way round-robin arbiter that grants a shared resource to one requester at a time and holds the grant for a whole transaction. A transaction ends when the owner signals completion, when the owner drops its request, or when a hold-limit counter expires. The block sits between the requester ports and the shared datapath. It replaces purely per-cycle arbitration wherever the resource needs multi-cycle ownership. Every output is registered.

## Interface
- `N`, 16: number of requesters; must be a power of two, 2..16.
- `IDXW`, 4: index width, equal to log2(N).
- `MAX_HOLD`, 8: maximum number of consecutive cycles a grant stays asserted; legal range 1..255.
- `clk` input, 1 bit: the single clock; all state changes on its rising edge.
- `rst` input, 1 bit: reset, synchronous and active-high.
- `req` input, N bits: request vector; bit i asserted means requester i wants the resource.
- `done` input, 1 bit: end-of-transaction from the current owner; sampled only while `gnt_vld`=1.
- `gnt` output, N bits: one-hot grant, or all-zero when no grant is active.
- `gnt_idx` output, IDXW bits: binary index of the current or most recent owner.
- `gnt_vld` output, 1 bit: high exactly when `gnt` is non-zero.
- `timeout` output, 1 bit: one-cycle pulse marking a release forced by the hold limit.

## Operation
- **Internal state:**
  - `ptr`, IDXW bits: highest-priority index.
  - `hold_cnt`, 8 bits.
  - FSM state: IDLE or BUSY.
- **Arbitration** is evaluated only in IDLE:
  - Scan circular order `ptr`, `ptr`+1, …, `ptr`+N-1, all mod N.
  - The first index i with `req[i]`=1 wins.
  - `req`=0 means no winner; stay in IDLE.
- **IDLE → BUSY** on a winner:
  - `gnt` <= one-hot(i), `gnt_idx` <= i, `gnt_vld` <= 1, `hold_cnt` <= 0.
- **BUSY:** `hold_cnt` increments each cycle; `req` bits of non-owners are ignored. Release is evaluated every cycle, in this priority:
  - (a) `done`=1;
  - (b) `req[gnt_idx]`=0;
  - (c) `hold_cnt`=MAX_HOLD-1.
- **BUSY → IDLE** on any release:
  - `gnt` <= 0, `gnt_vld` <= 0.
  - `ptr` <= (`gnt_idx`+1) mod N, wrapping 15 → 0 for N=16.
  - `gnt_idx` keeps its value.
  - `timeout` <= 1 only if (c) is the sole release cause; otherwise 0.
- **Fairness:** after serving i, the next priority order is i+1, …, i-1, i. The order is a strict rotation with no skipped indices.
- **Timeout pulse:** `timeout` is 0 in every cycle except the single cycle following a timeout release.
- **Simultaneous events:**
  - `done` and the hold limit in the same cycle count as a normal release; `timeout`=0.
  - `done` with `gnt_vld`=0 is ignored.

## Timing
- **Reset** (`rst`=1 at an edge) forces:
  - `gnt`=0, `gnt_idx`=0, `gnt_vld`=0, `timeout`=0;
  - `ptr`=0, `hold_cnt`=0, state IDLE.
  - This holds regardless of state, including mid-grant. `rst` overrides every other input in the same cycle.
- **Grant latency:** `req` sampled at edge k in IDLE → `gnt` visible after edge k; a 1-cycle latency.
- **Grant duration:**
  - With `done` sampled in the m-th grant cycle (m ≤ MAX_HOLD), `gnt` is high for exactly m cycles.
  - With no `done` and `req` held, `gnt` is high for exactly MAX_HOLD cycles.
- **Bubble:**
  - At least one cycle with `gnt`=0 (the IDLE cycle) separates consecutive grants.
  - Back-to-back grants to the same requester are allowed after that bubble.
- **Steady-state throughput:** all requesters active with 1-cycle transactions gives one grant every 2 cycles.
- **MAX_HOLD=1:** every grant lasts 1 cycle. `timeout` pulses unless `done`=1 or `req[gnt_idx]`=0 in that cycle.
- **Output invariants:**
  - `gnt` is never multi-hot.
  - `gnt_vld` equals the OR-reduction of `gnt` at all times.
  - When `gnt_vld`=1, `gnt[gnt_idx]`=1.

## Test plan
- **Single requester, completion:** `rst` then `req`=16'h0001 held, `done`=1 in the 3rd grant cycle → `gnt`=16'h0001 for exactly 3 cycles starting 1 cycle after `req`; then 1 idle cycle; then re-grant to 0; `ptr`=1 after the release.
- **Full rotation:** `req`=16'hFFFF held, `done`=1 in every grant cycle → `gnt_idx` sequence 0,1,2,…,15,0 with `gnt` toggling every cycle (grant, idle, grant, …); `timeout` never asserts.
- **Hold-limit release:** `MAX_HOLD`=8, `req`=16'h0020 held, `done`=0 → `gnt`=16'h0020 for exactly 8 cycles; `timeout`=1 for one cycle as `gnt` drops; re-grant to index 5 after 1 idle cycle.
- **Wrap-around:** serve index 14 (`ptr`=15), then `req`=16'h8001 → grant 15 first, then after its release grant 0.
- **Owner drops request:** with `gnt`=16'h0004, deassert `req[2]` → `gnt`=0 next cycle, `timeout`=0, `ptr`=3; `done` pulsed while idle has no effect.
- **Reset mid-grant:** `rst` asserted while `gnt`=16'h0100 → next cycle all outputs 0 and `ptr`=0; then `req`=16'h0101 → grant to index 0 first.
